fpmul_sp_arbiter: RTL and testbench

FPMUL_SP_ARBITER -- requirements
Module: fpmul_sp_arbiter

---
 rtl/fpmul_sp_arbiter.sv | 149 ++++++++++++++
 tb/tb_fpmul_sp_arbiter.sv | 294 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fpmul_sp_arbiter.sv
// ---------------------------------------------------------------------------
// fpmul_sp_arbiter
//
// Shares one pipelined FloPoCo single-precision multiplier (FPMul_sp_param)
// between NUM_REQ requesters. A round-robin arbiter picks one requester per
// cycle and steers its operands to the multiplier. A tag pipeline of
// NUM_STAGES entries (valid + requester id) travels alongside the
// multiplier's data registers, so the result on mul_r can be labelled with
// its owner when it leaves the pipe. A held result (out_ready=0) freezes the
// whole pipe through mul_ce.
//
// Ports
//   clk        single clock, rising edge
//   rst        asynchronous, active-high reset
//   req_valid  [NUM_REQ]       per-requester operation request
//   req_ready  [NUM_REQ]       per-requester accept (transfer = valid & ready)
//   req_x/y    [NUM_REQ*34]    packed operands, requester i at [34*i +: 34]
//   mul_x/y    [34]            operands to the multiplier
//   mul_ce                     multiplier clock enable
//   mul_r      [34]            multiplier result
//   out_valid                  result available
//   out_ready                  consumer accepts result
//   out_r      [34]            result (mul_r passed through)
//   out_id     [clog2(NUM_REQ)]       owner of the result
//   inflight   [clog2(NUM_STAGES+2)]  operations issued, not yet delivered
// ---------------------------------------------------------------------------
module fpmul_sp_arbiter #(
  parameter int NUM_REQ    = 4,
  parameter int NUM_STAGES = 6
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic [NUM_REQ-1:0]                req_valid,
  output logic [NUM_REQ-1:0]                req_ready,
  input  logic [NUM_REQ*34-1:0]             req_x,
  input  logic [NUM_REQ*34-1:0]             req_y,
  output logic [33:0]                       mul_x,
  output logic [33:0]                       mul_y,
  output logic                              mul_ce,
  input  logic [33:0]                       mul_r,
  output logic                              out_valid,
  input  logic                              out_ready,
  output logic [33:0]                       out_r,
  output logic [$clog2(NUM_REQ)-1:0]        out_id,
  output logic [$clog2(NUM_STAGES+2)-1:0]   inflight
);

  localparam int IDW  = $clog2(NUM_REQ);
  localparam int CNTW = $clog2(NUM_STAGES + 2);
  localparam logic [IDW-1:0] LAST_ID = IDW'(NUM_REQ - 1);

  // Tag pipeline, one entry per multiplier data stage.
  logic [NUM_STAGES-1:0] tag_valid;
  logic [IDW-1:0]        tag_id [NUM_STAGES];

  logic [IDW-1:0]  last_grant;
  logic [IDW-1:0]  grant_idx;
  logic            grant_any;
  logic            transfer;
  logic            deliver;
  logic [CNTW-1:0] inflight_q;

  // -------------------------------------------------------------------------
  // Output side: the last tag labels whatever the multiplier presents now.
  // -------------------------------------------------------------------------
  assign out_valid = tag_valid[NUM_STAGES-1];
  assign out_id    = tag_id[NUM_STAGES-1];
  assign out_r     = mul_r;
  assign inflight  = inflight_q;

  // A result that cannot leave freezes every stage, data and tags alike.
  assign mul_ce  = ~(out_valid & ~out_ready);
  assign deliver = out_valid & out_ready;

  // -------------------------------------------------------------------------
  // Round-robin search starting just after the last accepted requester.
  // Depends only on req_valid and last_grant, never on operand data.
  // -------------------------------------------------------------------------
  always_comb begin
    int unsigned cand;
    grant_any = 1'b0;
    grant_idx = '0;
    cand      = 0;
    for (int unsigned off = 1; off <= NUM_REQ; off++) begin
      cand = (32'(last_grant) + off) % NUM_REQ;
      if (!grant_any && req_valid[cand]) begin
        grant_any = 1'b1;
        grant_idx = IDW'(cand);
      end
    end
  end

  // Accept only while the pipe moves and never during reset.
  always_comb begin
    req_ready = '0;
    if (grant_any && mul_ce && !rst) begin
      req_ready[grant_idx] = 1'b1;
    end
  end

  assign transfer = |(req_valid & req_ready);

  // Operand steering; zero when nobody is requesting.
  always_comb begin
    mul_x = '0;
    mul_y = '0;
    if (grant_any) begin
      mul_x = req_x[34*int'(grant_idx) +: 34];
      mul_y = req_y[34*int'(grant_idx) +: 34];
    end
  end

  // -------------------------------------------------------------------------
  // Tag pipeline and priority pointer; both hold while mul_ce=0.
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tag_valid  <= '0;
      last_grant <= LAST_ID;
      for (int unsigned i = 0; i < NUM_STAGES; i++) begin
        tag_id[i] <= '0;
      end
    end else if (mul_ce) begin
      tag_valid[0] <= transfer;
      tag_id[0]    <= transfer ? grant_idx : '0;
      for (int unsigned i = 1; i < NUM_STAGES; i++) begin
        tag_valid[i] <= tag_valid[i-1];
        tag_id[i]    <= tag_id[i-1];
      end
      if (transfer) begin
        last_grant <= grant_idx;
      end
    end
  end

  // In-flight counter: issue and delivery in one cycle cancel out.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      inflight_q <= '0;
    end else begin
      case ({transfer, deliver})
        2'b10:   inflight_q <= inflight_q + CNTW'(1);
        2'b01:   inflight_q <= inflight_q - CNTW'(1);
        default: inflight_q <= inflight_q;
      endcase
    end
  end

endmodule

// File: tb/tb_fpmul_sp_arbiter.sv
module tb_fpmul_sp_arbiter;

  localparam int NR = 4;
  localparam int NS = 6;

  logic          clk;
  logic          rst;
  logic [NR-1:0] req_valid;
  logic [NR-1:0] req_ready;
  logic [NR*34-1:0] req_x, req_y;
  logic [33:0]   mul_x, mul_y, mul_r, out_r;
  logic          mul_ce, out_valid, out_ready;
  logic [1:0]    out_id;
  logic [2:0]    inflight;

  logic [33:0] rx [NR];
  logic [33:0] ry [NR];
  assign req_x = {rx[3], rx[2], rx[1], rx[0]};
  assign req_y = {ry[3], ry[2], ry[1], ry[0]};

  fpmul_sp_arbiter #(.NUM_REQ(NR), .NUM_STAGES(NS)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .req_x(req_x), .req_y(req_y), .mul_x(mul_x), .mul_y(mul_y),
    .mul_ce(mul_ce), .mul_r(mul_r), .out_valid(out_valid),
    .out_ready(out_ready), .out_r(out_r), .out_id(out_id),
    .inflight(inflight)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // FloPoCo single multiply for normal operands, truncating the fraction.
  function automatic logic [33:0] fmul(input logic [33:0] a, input logic [33:0] b);
    logic [47:0] p;
    int          e;
    logic [22:0] f;
    if (a[33:32] != 2'b01 || b[33:32] != 2'b01) return 34'h0;
    p = {24'h0, 1'b1, a[22:0]} * {24'h0, 1'b1, b[22:0]};
    e = int'(a[30:23]) + int'(b[30:23]) - 127;
    if (p[47]) begin f = p[46:24]; e++; end
    else f = p[45:23];
    if (e <= 0 || e >= 255) return 34'h0;
    return {2'b01, a[31] ^ b[31], e[7:0], f};
  endfunction

  function automatic logic [33:0] rand_fp();
    logic [7:0]  e;
    logic [22:0] f;
    e = 8'($urandom_range(100, 150));
    f = 23'($urandom);
    return {2'b01, 1'($urandom_range(0, 1)), e, f};
  endfunction

  // Multiplier stand-in: NS enabled stages, deliberately unreset.
  logic [33:0] mpipe [NS];
  always @(posedge clk) begin
    if (mul_ce) begin
      for (int i = NS - 1; i > 0; i--) mpipe[i] <= mpipe[i-1];
      mpipe[0] <= fmul(mul_x, mul_y);
    end
  end
  assign mul_r = mpipe[NS-1];

  // Reference model: list of outstanding operations with their age in
  // enabled cycles; an op is visible once its age reaches NS.
  typedef struct {
    int          id;
    logic [33:0] r;
    int          age;
  } op_t;
  op_t q[$];
  int  m_last;

  logic          e_ov, e_ce, e_found;
  int            e_grant;
  logic [NR-1:0] e_ready;
  logic [1:0]    e_id;
  logic [33:0]   e_r;
  logic [2:0]    e_inflight;

  int vectors = 0;
  int miscompares = 0;

  function automatic void predict();
    e_ov    = (q.size() > 0) && (q[0].age == NS);
    e_ce    = !(e_ov && !out_ready);
    e_found = 1'b0;
    e_grant = 0;
    for (int off = 1; off <= NR; off++) begin
      int c;
      c = (m_last + off) % NR;
      if (!e_found && req_valid[c]) begin
        e_found = 1'b1;
        e_grant = c;
      end
    end
    e_ready    = (e_found && e_ce) ? NR'(1 << e_grant) : '0;
    e_id       = e_ov ? 2'(q[0].id) : 2'd0;
    e_r        = e_ov ? q[0].r : 34'h0;
    e_inflight = 3'(q.size());
  endfunction

  task automatic advance();
    op_t n;
    @(posedge clk);
    if (e_ce) begin
      if (e_ov && out_ready) void'(q.pop_front());
      foreach (q[i]) q[i].age++;
      if (e_found) begin
        n.id  = e_grant;
        n.r   = fmul(rx[e_grant], ry[e_grant]);
        n.age = 1;
        q.push_back(n);
        m_last = e_grant;
      end
    end
    #1;
  endtask

  task automatic model_reset();
    q.delete();
    m_last = NR - 1;
  endtask

  task automatic randomize_ops();
    for (int i = 0; i < NR; i++) begin
      rx[i] = rand_fp();
      ry[i] = rand_fp();
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; req_valid = '1; out_ready = 1'b0;
    randomize_ops();
    model_reset();
    @(negedge clk);
    vectors++; if (out_valid !== 1'b0) begin miscompares++; $display("FAIL rst_out_valid got=%b want=0", out_valid); end
    vectors++; if (req_ready !== 4'b0000) begin miscompares++; $display("FAIL rst_req_ready got=%b want=0000", req_ready); end
    vectors++; if (mul_ce !== 1'b1) begin miscompares++; $display("FAIL rst_mul_ce got=%b want=1", mul_ce); end
    vectors++; if (inflight !== 3'd0) begin miscompares++; $display("FAIL rst_inflight got=%0d want=0", inflight); end
    @(posedge clk); #1;
    rst = 1'b0;
    req_valid = '0;
  endtask

  task automatic test_single_op();
    logic ov_want;
    logic [2:0] inf_want;
    rx[2] = 34'h13F800000; ry[2] = 34'h140000000;
    req_valid = 4'b0100; out_ready = 1'b1;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk); predict();
      ov_want  = (k == 6);
      inf_want = (k >= 1 && k <= 6) ? 3'd1 : 3'd0;
      vectors++; if (req_ready !== e_ready) begin miscompares++; $display("FAIL single_ready k=%0d got=%b want=%b", k, req_ready, e_ready); end
      vectors++; if (out_valid !== ov_want) begin miscompares++; $display("FAIL single_out_valid k=%0d got=%b want=%b", k, out_valid, ov_want); end
      vectors++; if (inflight !== inf_want) begin miscompares++; $display("FAIL single_inflight k=%0d got=%0d want=%0d", k, inflight, inf_want); end
      if (k == 6) begin
        vectors++; if (out_r !== 34'h140000000) begin miscompares++; $display("FAIL single_out_r got=%h want=140000000", out_r); end
        vectors++; if (out_id !== 2'd2) begin miscompares++; $display("FAIL single_out_id got=%0d want=2", out_id); end
      end
      advance();
      req_valid = '0;
    end
  endtask

  task automatic test_round_robin();
    logic [NR-1:0] rr_want;
    rst = 1'b1; #2; rst = 1'b0;
    model_reset();
    out_ready = 1'b1;
    for (int k = 0; k < 28; k++) begin
      req_valid = (k < 20) ? 4'b1111 : 4'b0000;
      randomize_ops();
      @(negedge clk); predict();
      vectors++; if (req_ready !== e_ready) begin miscompares++; $display("FAIL rr_ready k=%0d got=%b want=%b", k, req_ready, e_ready); end
      vectors++; if (out_valid !== e_ov) begin miscompares++; $display("FAIL rr_out_valid k=%0d got=%b want=%b", k, out_valid, e_ov); end
      vectors++; if (inflight !== e_inflight) begin miscompares++; $display("FAIL rr_inflight k=%0d got=%0d want=%0d", k, inflight, e_inflight); end
      if (e_ov) begin
        vectors++; if ({out_id, out_r} !== {e_id, e_r}) begin miscompares++; $display("FAIL rr_result k=%0d got=%0d/%h want=%0d/%h", k, out_id, out_r, e_id, e_r); end
      end
      if (k < 20) begin
        rr_want = NR'(1 << (k % 4));
        vectors++; if (req_ready !== rr_want) begin miscompares++; $display("FAIL rr_seq k=%0d got=%b want=%b", k, req_ready, rr_want); end
      end
      if (k >= 6 && k < 26) begin
        vectors++; if (out_valid !== 1'b1 || out_id !== 2'((k - 6) % 4)) begin miscompares++; $display("FAIL rr_out_seq k=%0d got=%b/%0d want=1/%0d", k, out_valid, out_id, (k - 6) % 4); end
      end
      advance();
    end
  endtask

  task automatic test_backpressure();
    int delivered = 0;
    for (int k = 0; k < 32; k++) begin
      req_valid = (k < 20) ? 4'b0010 : 4'b0000;
      out_ready = !(k >= 6 && k < 9);
      rx[1] = rand_fp(); ry[1] = rand_fp();
      @(negedge clk); predict();
      vectors++; if (req_ready !== e_ready) begin miscompares++; $display("FAIL bp_ready k=%0d got=%b want=%b", k, req_ready, e_ready); end
      vectors++; if (mul_ce !== e_ce) begin miscompares++; $display("FAIL bp_mul_ce k=%0d got=%b want=%b", k, mul_ce, e_ce); end
      vectors++; if (out_valid !== e_ov) begin miscompares++; $display("FAIL bp_out_valid k=%0d got=%b want=%b", k, out_valid, e_ov); end
      vectors++; if (inflight !== e_inflight) begin miscompares++; $display("FAIL bp_inflight k=%0d got=%0d want=%0d", k, inflight, e_inflight); end
      if (e_ov) begin
        vectors++; if ({out_id, out_r} !== {e_id, e_r}) begin miscompares++; $display("FAIL bp_result k=%0d got=%0d/%h want=%0d/%h", k, out_id, out_r, e_id, e_r); end
      end
      if (k >= 6 && k < 9) begin
        vectors++; if ({mul_ce, req_ready, inflight, out_id} !== {1'b0, 4'b0000, 3'd6, 2'd1}) begin miscompares++; $display("FAIL bp_stall k=%0d got ce=%b rdy=%b inf=%0d id=%0d want ce=0 rdy=0000 inf=6 id=1", k, mul_ce, req_ready, inflight, out_id); end
      end
      if (k == 9) begin
        vectors++; if ({out_valid, req_ready, inflight} !== {1'b1, 4'b0010, 3'd6}) begin miscompares++; $display("FAIL bp_full_swap got ov=%b rdy=%b inf=%0d want ov=1 rdy=0010 inf=6", out_valid, req_ready, inflight); end
      end
      if (out_valid === 1'b1 && out_ready) delivered++;
      advance();
      if (k == 10) begin
        vectors++; if (inflight !== 3'd6) begin miscompares++; $display("FAIL bp_full_hold got=%0d want=6", inflight); end
      end
    end
    vectors++; if (delivered != 17) begin miscompares++; $display("FAIL bp_delivered got=%0d want=17", delivered); end
  endtask

  task automatic test_random();
    for (int k = 0; k < 420; k++) begin
      req_valid = (k < 400) ? NR'($urandom) : '0;
      out_ready = (k < 400) ? ($urandom_range(0, 3) != 0) : 1'b1;
      randomize_ops();
      @(negedge clk); predict();
      vectors++; if (req_ready !== e_ready) begin miscompares++; $display("FAIL rnd_ready k=%0d got=%b want=%b", k, req_ready, e_ready); end
      vectors++; if (mul_ce !== e_ce) begin miscompares++; $display("FAIL rnd_mul_ce k=%0d got=%b want=%b", k, mul_ce, e_ce); end
      vectors++; if (out_valid !== e_ov) begin miscompares++; $display("FAIL rnd_out_valid k=%0d got=%b want=%b", k, out_valid, e_ov); end
      vectors++; if (inflight !== e_inflight) begin miscompares++; $display("FAIL rnd_inflight k=%0d got=%0d want=%0d", k, inflight, e_inflight); end
      if (e_ov) begin
        vectors++; if ({out_id, out_r} !== {e_id, e_r}) begin miscompares++; $display("FAIL rnd_result k=%0d got=%0d/%h want=%0d/%h", k, out_id, out_r, e_id, e_r); end
      end
      if (e_found) begin
        vectors++; if ({mul_x, mul_y} !== {rx[e_grant], ry[e_grant]}) begin miscompares++; $display("FAIL rnd_operands k=%0d got=%h/%h want=%h/%h", k, mul_x, mul_y, rx[e_grant], ry[e_grant]); end
      end
      advance();
    end
  endtask

  task automatic test_reset_midop();
    req_valid = 4'b1111; out_ready = 1'b1;
    for (int k = 0; k < 10 && q.size() < 4; k++) begin
      randomize_ops();
      @(negedge clk); predict();
      vectors++; if (req_ready !== e_ready) begin miscompares++; $display("FAIL mid_fill_ready k=%0d got=%b want=%b", k, req_ready, e_ready); end
      advance();
    end
    vectors++; if (inflight !== 3'd4) begin miscompares++; $display("FAIL mid_fill_inflight got=%0d want=4", inflight); end
    rst = 1'b1;
    #1;
    vectors++; if ({out_valid, inflight, req_ready, mul_ce} !== {1'b0, 3'd0, 4'b0000, 1'b1}) begin miscompares++; $display("FAIL mid_rst_async got ov=%b inf=%0d rdy=%b ce=%b want ov=0 inf=0 rdy=0000 ce=1", out_valid, inflight, req_ready, mul_ce); end
    model_reset();
    @(posedge clk); #1;
    rst = 1'b0;
    for (int k = 0; k < 22; k++) begin
      req_valid = (k < 12) ? 4'b1111 : 4'b0000;
      randomize_ops();
      @(negedge clk); predict();
      vectors++; if (req_ready !== e_ready) begin miscompares++; $display("FAIL mid_ready k=%0d got=%b want=%b", k, req_ready, e_ready); end
      vectors++; if (out_valid !== e_ov) begin miscompares++; $display("FAIL mid_out_valid k=%0d got=%b want=%b", k, out_valid, e_ov); end
      vectors++; if (inflight !== e_inflight) begin miscompares++; $display("FAIL mid_inflight k=%0d got=%0d want=%0d", k, inflight, e_inflight); end
      if (e_ov) begin
        vectors++; if ({out_id, out_r} !== {e_id, e_r}) begin miscompares++; $display("FAIL mid_result k=%0d got=%0d/%h want=%0d/%h", k, out_id, out_r, e_id, e_r); end
      end
      if (k == 0) begin
        vectors++; if (req_ready !== 4'b0001) begin miscompares++; $display("FAIL mid_first_grant got=%b want=0001", req_ready); end
      end
      if (k < 6) begin
        vectors++; if (out_valid !== 1'b0) begin miscompares++; $display("FAIL mid_stale k=%0d got=%b want=0", k, out_valid); end
      end
      advance();
    end
  endtask

  initial begin
    test_reset();
    test_single_op();
    test_round_robin();
    test_backpressure();
    test_random();
    test_reset_midop();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
